eth_rx_frame_classifier: RTL and testbench

Byte-serial Ethernet receive front end. It strips the preamble/SFD, captures a parametrised-length header, and classifies each frame as ARP request, ICMP echo request, UDP or unmatched against the configured MAC/IP. It forwards the post-header bytes as a handshaked payload stream and reports per-frame status, optionally with CRC-32 FCS checking. It sits between the PHY byte source and the ARP/ICMP/UDP responders, replacing free-running header decode with frame-delimited, gap-tolerant operation.

---
 rtl/eth_rx_frame_classifier.sv | 252 +++++++++++++++++++++++++
 tb/tb_eth_rx_frame_classifier.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_frame_classifier.sv
`default_nettype none
// ============================================================================
// Module      : eth_rx_frame_classifier
// Description : Byte-serial Ethernet receive front end. Strips preamble/SFD,
//               captures HDR_BYTES header bytes, classifies the frame as
//               ARP request / ICMP echo request / UDP / unmatched against
//               FPGA_MAC and FPGA_IP, forwards post-header bytes (including
//               the 4 FCS bytes) as a payload stream and reports per-frame
//               status.
//               Optional CRC-32 FCS checking: define ETH_RX_FCS_CHECK_EN.
//               Without it every non-runt frame reports o_fcs_ok=1.
// Ports       : i_clk, i_reset (async, active-high)
//               i_data/i_valid/i_last  : PHY byte stream, gaps allowed
//               o_hdr/o_hdr_valid/o_class : captured header + classification
//               o_pay_data/o_pay_valid/o_pay_last : payload stream (1 cycle)
//               o_frame_done/o_fcs_ok/o_runt : end-of-frame status
//               o_drop_cnt : runt / FCS-bad / unmatched frame counter
// Revision    : 1.0 - initial release
// ============================================================================
module eth_rx_frame_classifier #(
    parameter logic [47:0] FPGA_MAC     = 48'h211abcdef112,
    parameter logic [31:0] FPGA_IP      = 32'hC0000186,
    parameter int          HDR_BYTES    = 42,
    parameter bit          ACCEPT_BCAST = 1'b1
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [7:0]             i_data,
    input  logic                   i_valid,
    input  logic                   i_last,
    output logic [HDR_BYTES*8-1:0] o_hdr,
    output logic                   o_hdr_valid,
    output logic [1:0]             o_class,
    output logic [7:0]             o_pay_data,
    output logic                   o_pay_valid,
    output logic                   o_pay_last,
    output logic                   o_frame_done,
    output logic                   o_fcs_ok,
    output logic                   o_runt,
    output logic [15:0]            o_drop_cnt
);

    localparam int              c_HB       = HDR_BYTES * 8;
    localparam int              c_CW       = $clog2(HDR_BYTES + 1);
    localparam logic [c_CW-1:0] c_LAST_HDR = c_CW'(HDR_BYTES - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_PRE  = 2'd1;
    localparam logic [1:0] c_HDR  = 2'd2;
    localparam logic [1:0] c_PAY  = 2'd3;

    localparam logic [1:0] c_CLS_NONE = 2'd0;
    localparam logic [1:0] c_CLS_ARP  = 2'd1;
    localparam logic [1:0] c_CLS_ICMP = 2'd2;
    localparam logic [1:0] c_CLS_UDP  = 2'd3;

    logic [1:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic [c_HB-9:0] r_shift;      // holds the most recent HDR_BYTES-1 bytes
    logic [c_HB-1:0] r_hdr;
    logic            r_hdr_valid;
    logic [1:0]      r_class;
    logic [7:0]      r_pay_data;
    logic            r_pay_valid;
    logic            r_pay_last;
    logic            r_frame_done;
    logic            r_fcs_ok;
    logic            r_runt;
    logic [15:0]     r_drop_cnt;

    logic [c_HB-1:0] w_hdr_next;
    logic            w_fcs_ok;
    logic            w_dst_ok;
    logic            w_dst_arp;
    logic            w_arp;
    logic            w_ipv4;
    logic            w_icmp;
    logic            w_udp;
    logic [1:0]      w_class;

    // Header including the byte currently on i_data; the shift register is
    // kept apart from r_hdr so o_hdr stays stable while the next frame's
    // header is being collected.
    assign w_hdr_next = {r_shift, i_data};

    // Extract n (<=6) bytes starting at header byte index 'at', big-endian,
    // right-aligned in the result.
    function automatic logic [47:0] f_fld(input logic [c_HB-1:0] h,
                                          input int at, input int n);
        logic [47:0] r;
        r = '0;
        for (int k = 0; k < n; k++) begin
            r = {r[39:0], h[c_HB-1-8*(at+k) -: 8]};
        end
        return r;
    endfunction

    assign w_dst_ok  = (f_fld(w_hdr_next, 0, 6) == FPGA_MAC);
    assign w_dst_arp = w_dst_ok ||
                       (ACCEPT_BCAST && (f_fld(w_hdr_next, 0, 6) == 48'hffff_ffff_ffff));

    assign w_arp  = w_dst_arp
                 && (f_fld(w_hdr_next, 12, 2) == 48'h0806)
                 && (f_fld(w_hdr_next, 14, 2) == 48'h0001)
                 && (f_fld(w_hdr_next, 16, 2) == 48'h0800)
                 && (f_fld(w_hdr_next, 20, 2) == 48'h0001)
                 && (f_fld(w_hdr_next, 32, 6) == FPGA_MAC)
                 && (f_fld(w_hdr_next, 38, 4) == 48'(FPGA_IP));

    assign w_ipv4 = w_dst_ok
                 && (f_fld(w_hdr_next, 12, 2) == 48'h0800)
                 && (f_fld(w_hdr_next, 14, 1) == 48'h45)
                 && (f_fld(w_hdr_next, 30, 4) == 48'(FPGA_IP));

    assign w_icmp = w_ipv4
                 && (f_fld(w_hdr_next, 23, 1) == 48'h01)
                 && (f_fld(w_hdr_next, 34, 2) == 48'h0800);

    assign w_udp  = w_ipv4 && (f_fld(w_hdr_next, 23, 1) == 48'h11);

    always_comb begin
        w_class = c_CLS_NONE;
        if (w_arp) begin
            w_class = c_CLS_ARP;
        end else if (w_icmp) begin
            w_class = c_CLS_ICMP;
        end else if (w_udp) begin
            w_class = c_CLS_UDP;
        end
    end

`ifdef ETH_RX_FCS_CHECK_EN
    logic [31:0] r_crc;
    logic [31:0] w_crc_next;

    // Reflected CRC-32, one byte, LSB first.
    function automatic logic [31:0] f_crc8(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h0, d};
        for (int k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    assign w_crc_next = f_crc8(r_crc, i_data);
    // Running the CRC across the received FCS leaves the fixed residue.
    assign w_fcs_ok   = (w_crc_next == 32'hDEBB20E3);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_crc <= 32'hFFFF_FFFF;
        end else if (i_valid) begin
            if (r_state == c_PRE && i_data == 8'hD5) begin
                r_crc <= 32'hFFFF_FFFF;
            end else if (r_state == c_HDR || r_state == c_PAY) begin
                r_crc <= w_crc_next;
            end
        end
    end
`else
    assign w_fcs_ok = 1'b1;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= c_IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_hdr        <= '0;
            r_hdr_valid  <= 1'b0;
            r_class      <= c_CLS_NONE;
            r_pay_data   <= 8'h00;
            r_pay_valid  <= 1'b0;
            r_pay_last   <= 1'b0;
            r_frame_done <= 1'b0;
            r_fcs_ok     <= 1'b0;
            r_runt       <= 1'b0;
            r_drop_cnt   <= 16'h0000;
        end else begin
            r_hdr_valid  <= 1'b0;
            r_pay_valid  <= 1'b0;
            r_pay_last   <= 1'b0;
            r_frame_done <= 1'b0;
            if (i_valid) begin
                case (r_state)
                    c_IDLE: begin
                        if (i_data == 8'h55) begin
                            r_state <= c_PRE;
                        end
                    end
                    c_PRE: begin
                        if (i_data == 8'hD5) begin
                            r_state <= c_HDR;
                            r_cnt   <= '0;
                        end else if (i_data != 8'h55) begin
                            r_state <= c_IDLE;
                        end
                    end
                    c_HDR: begin
                        r_shift <= w_hdr_next[c_HB-9:0];
                        if (i_last) begin
                            // Frame ended inside the header: runt.
                            r_state      <= c_IDLE;
                            r_frame_done <= 1'b1;
                            r_runt       <= 1'b1;
                            r_fcs_ok     <= 1'b0;
                            r_drop_cnt   <= r_drop_cnt + 16'd1;
                        end else begin
                            r_cnt <= r_cnt + c_CW'(1);
                            if (r_cnt == c_LAST_HDR) begin
                                r_state     <= c_PAY;
                                r_hdr       <= w_hdr_next;
                                r_class     <= w_class;
                                r_hdr_valid <= 1'b1;
                            end
                        end
                    end
                    default: begin // c_PAY
                        if (r_class != c_CLS_NONE) begin
                            r_pay_data  <= i_data;
                            r_pay_valid <= 1'b1;
                            r_pay_last  <= i_last;
                        end
                        if (i_last) begin
                            r_state      <= c_IDLE;
                            r_frame_done <= 1'b1;
                            r_runt       <= 1'b0;
                            r_fcs_ok     <= w_fcs_ok;
                            if (!w_fcs_ok || r_class == c_CLS_NONE) begin
                                r_drop_cnt <= r_drop_cnt + 16'd1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign o_hdr        = r_hdr;
    assign o_hdr_valid  = r_hdr_valid;
    assign o_class      = r_class;
    assign o_pay_data   = r_pay_data;
    assign o_pay_valid  = r_pay_valid;
    assign o_pay_last   = r_pay_last;
    assign o_frame_done = r_frame_done;
    assign o_fcs_ok     = r_fcs_ok;
    assign o_runt       = r_runt;
    assign o_drop_cnt   = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_frame_classifier.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_rx_frame_classifier
// Description : Scoreboard bench for eth_rx_frame_classifier. Stimulus tasks
//               build frames from field values, push expected header,
//               payload and end-of-frame records into queues; a monitor
//               pops and compares whenever the DUT presents an output.
//               Honours ETH_RX_FCS_CHECK_EN when deciding expected FCS.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_rx_frame_classifier;

    localparam logic [47:0] c_MAC = 48'h211abcdef112;
    localparam logic [31:0] c_IP  = 32'hC0000186;
    localparam int          c_HB  = 42;

    typedef logic [7:0] bq_t [$];
    typedef struct { logic [335:0] hdr; logic [1:0] cls; } hdr_exp_t;
    typedef struct { logic [7:0] d; logic last; } pay_exp_t;
    typedef struct { logic runt; logic ok; logic [15:0] drop; } done_exp_t;

    logic         clk = 1'b0;
    logic         i_reset;
    logic [7:0]   i_data;
    logic         i_valid;
    logic         i_last;
    logic [335:0] o_hdr;
    logic         o_hdr_valid;
    logic [1:0]   o_class;
    logic [7:0]   o_pay_data;
    logic         o_pay_valid;
    logic         o_pay_last;
    logic         o_frame_done;
    logic         o_fcs_ok;
    logic         o_runt;
    logic [15:0]  o_drop_cnt;

    hdr_exp_t  exp_hdr[$];
    pay_exp_t  exp_pay[$];
    done_exp_t exp_done[$];
    hdr_exp_t  mh;
    pay_exp_t  mp;
    done_exp_t md;

    int          n_vec = 0;
    int          n_fail = 0;
    int          pay_beats = 0;
    logic [15:0] model_drop = 16'h0;
    bq_t         hq;

    always #5 clk = ~clk;

    eth_rx_frame_classifier #(
        .FPGA_MAC(c_MAC), .FPGA_IP(c_IP), .HDR_BYTES(c_HB), .ACCEPT_BCAST(1'b1)
    ) dut (
        .i_clk(clk), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid),
        .i_last(i_last), .o_hdr(o_hdr), .o_hdr_valid(o_hdr_valid),
        .o_class(o_class), .o_pay_data(o_pay_data), .o_pay_valid(o_pay_valid),
        .o_pay_last(o_pay_last), .o_frame_done(o_frame_done),
        .o_fcs_ok(o_fcs_ok), .o_runt(o_runt), .o_drop_cnt(o_drop_cnt)
    );

    task automatic chk(input string nm, input logic [335:0] act, input logic [335:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit eqn(input bq_t h, input int at, input logic [47:0] v, input int n);
        for (int k = 0; k < n; k++) begin
            if (h[at+k] != v[8*(n-1-k) +: 8]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [1:0] classify(input bq_t h);
        bit mac, arp, ip4;
        mac = eqn(h, 0, c_MAC, 6);
        arp = (mac || eqn(h, 0, 48'hffffffffffff, 6)) && eqn(h, 12, 48'h0806, 2)
              && eqn(h, 14, 48'h1, 2) && eqn(h, 16, 48'h0800, 2) && eqn(h, 20, 48'h1, 2)
              && eqn(h, 32, c_MAC, 6) && eqn(h, 38, 48'(c_IP), 4);
        ip4 = mac && eqn(h, 12, 48'h0800, 2) && h[14] == 8'h45 && eqn(h, 30, 48'(c_IP), 4);
        if (arp) return 2'd1;
        if (ip4 && h[23] == 8'h01 && h[34] == 8'h08 && h[35] == 8'h00) return 2'd2;
        if (ip4 && h[23] == 8'h11) return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [31:0] crc32(input bq_t s);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (s[i]) begin
            c ^= {24'h0, s[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    task automatic setf(input int at, input logic [47:0] v, input int n);
        for (int k = 0; k < n; k++) hq[at+k] = v[8*(n-1-k) +: 8];
    endtask

    // kind: 0 ARP, 1 ARP broadcast, 2 ICMP echo, 3 UDP, 4 random bytes
    task automatic mk_hdr(input int kind);
        hq = {};
        for (int k = 0; k < c_HB; k++) hq.push_back(8'($urandom));
        if (kind <= 1) begin
            setf(0, (kind == 1) ? 48'hffffffffffff : c_MAC, 6);
            setf(12, 48'h0806, 2); setf(14, 48'h0001, 2); setf(16, 48'h0800, 2);
            hq[18] = 8'h06; hq[19] = 8'h04; setf(20, 48'h0001, 2);
            setf(32, c_MAC, 6); setf(38, 48'(c_IP), 4);
        end else if (kind <= 3) begin
            setf(0, c_MAC, 6); setf(12, 48'h0800, 2); hq[14] = 8'h45;
            hq[23] = (kind == 2) ? 8'h01 : 8'h11; setf(30, 48'(c_IP), 4);
            if (kind == 2) begin hq[34] = 8'h08; hq[35] = 8'h00; end
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic send(input logic [7:0] b, input bit last, input int gap_max);
        int g;
        g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        repeat (g) begin @(posedge clk); #1; end
        i_data = b; i_valid = 1'b1; i_last = last;
        @(posedge clk); #1;
        i_valid = 1'b0; i_last = 1'b0;
    endtask

    task automatic send_frame(input bq_t h, input int paylen, input bit corrupt,
                              input int gap_max, input int npre, input int runt_len,
                              input int abort_pay);
        bq_t s; logic [31:0] fcs; logic [1:0] cls; logic [335:0] hb; bit ok, last; int idx;
        s = h;
        repeat (paylen) s.push_back(8'($urandom));
        fcs = ~crc32(s);
        for (int k = 0; k < 4; k++) s.push_back(fcs[8*k +: 8]);
        if (corrupt) begin
            idx = s.size() - 1 - int'($urandom_range(0, 3));
            s[idx] ^= 8'(1 << $urandom_range(0, 7));
        end
        repeat (npre) send(8'h55, 1'b0, gap_max);
        send(8'hD5, 1'b0, gap_max);
        if (runt_len > 0) begin
            for (int i = 0; i < runt_len; i++) begin
                last = (i == runt_len - 1);
                if (last) begin
                    model_drop++;
                    exp_done.push_back('{runt: 1'b1, ok: 1'b0, drop: model_drop});
                end
                send(s[i], last, gap_max);
            end
        end else begin
            cls = classify(h);
            hb = '0;
            for (int i = 0; i < c_HB; i++) hb = {hb[327:0], h[i]};
            exp_hdr.push_back('{hdr: hb, cls: cls});
            for (int i = 0; i < s.size(); i++) begin
                if (abort_pay >= 0 && i >= c_HB + abort_pay) break;
                last = (i == s.size() - 1);
                if (i >= c_HB && cls != 2'd0) exp_pay.push_back('{d: s[i], last: last});
                if (last) begin
`ifdef ETH_RX_FCS_CHECK_EN
                    ok = !corrupt;
`else
                    ok = 1'b1;
`endif
                    if (!ok || cls == 2'd0) model_drop++;
                    exp_done.push_back('{runt: 1'b0, ok: ok, drop: model_drop});
                end
                send(s[i], last, gap_max);
            end
        end
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_hdr"}, o_hdr, '0);
        chk({p, "_hdr_valid"}, 336'(o_hdr_valid), '0);
        chk({p, "_class"}, 336'(o_class), '0);
        chk({p, "_pay_data"}, 336'(o_pay_data), '0);
        chk({p, "_pay_valid"}, 336'(o_pay_valid), '0);
        chk({p, "_pay_last"}, 336'(o_pay_last), '0);
        chk({p, "_frame_done"}, 336'(o_frame_done), '0);
        chk({p, "_fcs_ok"}, 336'(o_fcs_ok), '0);
        chk({p, "_runt"}, 336'(o_runt), '0);
        chk({p, "_drop_cnt"}, 336'(o_drop_cnt), '0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!i_reset) begin
            if (o_hdr_valid) begin
                if (exp_hdr.size() == 0) chk("hdr_valid_unexpected", 336'(o_hdr_valid), '0);
                else begin
                    mh = exp_hdr.pop_front();
                    chk("hdr", o_hdr, mh.hdr);
                    chk("class", 336'(o_class), 336'(mh.cls));
                end
            end
            if (o_pay_valid) begin
                pay_beats++;
                if (exp_pay.size() == 0) chk("pay_valid_unexpected", 336'(o_pay_valid), '0);
                else begin
                    mp = exp_pay.pop_front();
                    chk("pay_data", 336'(o_pay_data), 336'(mp.d));
                    chk("pay_last", 336'(o_pay_last), 336'(mp.last));
                end
            end
            if (o_frame_done) begin
                if (exp_done.size() == 0) chk("frame_done_unexpected", 336'(o_frame_done), '0);
                else begin
                    md = exp_done.pop_front();
                    chk("runt", 336'(o_runt), 336'(md.runt));
                    chk("fcs_ok", 336'(o_fcs_ok), 336'(md.ok));
                    chk("drop_cnt", 336'(o_drop_cnt), 336'(md.drop));
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int b0;
        i_reset = 1'b1; i_data = 8'h00; i_valid = 1'b0; i_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst");
        i_reset = 1'b0;

        // ARP request, full preamble, good FCS
        mk_hdr(0);
        send_frame(hq, 18, 1'b0, 0, 7, 0, -1);
        settle();
        chk("arp_class", 336'(o_class), 336'd1);
        chk("arp_dst", 336'(o_hdr[335:288]), 336'(c_MAC));
        chk("arp_drop", 336'(o_drop_cnt), 336'(model_drop));

        // ICMP echo, 32-byte payload, random gaps
        mk_hdr(2);
        b0 = pay_beats;
        send_frame(hq, 32, 1'b0, 3, 7, 0, -1);
        settle();
        chk("icmp_class", 336'(o_class), 336'd2);
        chk("icmp_beats", 336'(pay_beats - b0), 336'd36);

        // UDP with a flipped FCS bit
        mk_hdr(3);
        send_frame(hq, 10, 1'b1, 1, 7, 0, -1);
        settle();
        chk("udp_class", 336'(o_class), 336'd3);
        chk("udp_drop", 336'(o_drop_cnt), 336'(model_drop));

        // Runt: ends after 20 header bytes
        mk_hdr(3);
        send_frame(hq, 0, 1'b0, 0, 7, 20, -1);
        settle();
        chk("runt_drop", 336'(o_drop_cnt), 336'(model_drop));

        // Broken preamble then valid frame
        send(8'h55, 1'b0, 0); send(8'h55, 1'b0, 0); send(8'hAA, 1'b0, 0);
        mk_hdr(0);
        send_frame(hq, 5, 1'b0, 0, 7, 0, -1);
        settle();
        chk("pre_retry_class", 336'(o_class), 336'd1);

        // Randomised frames, including zero IFG and stray i_last in IDLE/PRE
        for (int f = 0; f < 30; f++) begin
            int kind, gap, rl;
            bit bad;
            kind = int'($urandom_range(0, 4));
            gap  = int'($urandom_range(0, 3));
            bad  = ($urandom_range(0, 3) == 0);
            rl   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 41)) : 0;
            if ($urandom_range(0, 3) == 0) send(8'h12, 1'b1, gap);
            if ($urandom_range(0, 3) == 0) begin
                send(8'h55, 1'b0, gap); send(8'h55, 1'b1, gap);
            end
            mk_hdr(kind);
            if ($urandom_range(0, 5) == 0) begin
                int p;
                p = int'($urandom_range(0, c_HB - 1));
                hq[p] = hq[p] ^ 8'(1 << $urandom_range(0, 7));
            end
            send_frame(hq, int'($urandom_range(0, 40)), bad, gap,
                       int'($urandom_range(1, 7)), rl, -1);
        end
        settle();

        // Reset in the middle of the payload
        mk_hdr(2);
        send_frame(hq, 20, 1'b0, 0, 7, 0, 10);
        @(posedge clk); #1;
        i_reset = 1'b1;
        #1;
        chk_reset("midpay");
        chk("midpay_pay_pending", 336'(exp_pay.size()), '0);
        chk("midpay_hdr_pending", 336'(exp_hdr.size()), '0);
        exp_done.delete();
        model_drop = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        i_reset = 1'b0;
        // Remainder without a fresh preamble must be ignored
        send(8'hD5, 1'b0, 0);
        for (int k = 0; k < 8; k++) send(8'(k * 3), k == 7, 0);
        mk_hdr(2);
        send_frame(hq, 6, 1'b0, 0, 7, 0, -1);
        settle();
        chk("post_reset_class", 336'(o_class), 336'd2);
        chk("post_reset_drop", 336'(o_drop_cnt), 336'(model_drop));

        repeat (5) @(posedge clk);
        #1;
        chk("hdr_queue_empty", 336'(exp_hdr.size()), '0);
        chk("pay_queue_empty", 336'(exp_pay.size()), '0);
        chk("done_queue_empty", 336'(exp_done.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
